rom_operand_sequencer: RTL and testbench

- Sequences operand fetches from the 8-entry, 8-bit dual-port operand ROM. Both ROM ports are read combinationally.
- On a start command, it walks port A and port B through programmable address sequences. Each fetched (opA, opB) pair is registered and presented downstream with a valid/ready handshake.
- Sits between the ROM and the arithmetic/kinematics datapath. It is the only block that drives the ROM addresses.

---
 rtl/rom_operand_sequencer.sv | 149 ++++++++++++++
 tb/tb_rom_operand_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_operand_sequencer.sv
// rtl/rom_operand_sequencer.sv - walks two ROM ports through address sequences and presents operand pairs
module rom_operand_sequencer #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [ADDR_W-1:0] stride_b,
    input  logic [LEN_W-1:0]  len,
    output logic [ADDR_W-1:0] rom_addr_a,
    output logic [ADDR_W-1:0] rom_addr_b,
    input  logic [DATA_W-1:0] rom_q_a,
    input  logic [DATA_W-1:0] rom_q_b,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [LEN_W-1:0]  op_idx,
    output logic              op_valid,
    input  logic              op_ready,
    output logic              op_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_PRESENT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_a_q, ptr_a_d;
    logic [ADDR_W-1:0] ptr_b_q, ptr_b_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] op_a_q, op_a_d;
    logic [DATA_W-1:0] op_b_q, op_b_d;
    logic [LEN_W-1:0]  op_idx_q, op_idx_d;
    logic              op_valid_q, op_valid_d;

    logic              handshake;
    logic [LEN_W-1:0]  last_idx;

    assign handshake = op_valid_q & op_ready;
    // len_q is never 0 while a pair is presented, so this does not underflow in use
    assign last_idx  = len_q - LEN_W'(1);

    // Next-state and datapath updates; abort outside IDLE overrides everything else
    always_comb begin
        state_d    = state_q;
        ptr_a_d    = ptr_a_q;
        ptr_b_d    = ptr_b_q;
        stride_d   = stride_q;
        len_d      = len_q;
        idx_d      = idx_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_idx_d   = op_idx_q;
        op_valid_d = op_valid_q;

        if (abort && (state_q != S_IDLE)) begin
            state_d    = S_IDLE;
            op_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        ptr_a_d  = base_a;
                        ptr_b_d  = base_b;
                        stride_d = stride_b;
                        len_d    = len;
                        idx_d    = '0;
                        state_d  = (len == '0) ? S_DONE : S_FETCH;
                    end
                end
                S_FETCH: begin
                    op_a_d     = rom_q_a;
                    op_b_d     = rom_q_b;
                    op_idx_d   = idx_q;
                    op_valid_d = 1'b1;
                    state_d    = S_PRESENT;
                end
                S_PRESENT: begin
                    if (handshake) begin
                        op_valid_d = 1'b0;
                        if (idx_q == last_idx) begin
                            state_d = S_DONE;
                        end else begin
                            idx_d   = idx_q + LEN_W'(1);
                            ptr_a_d = ptr_a_q + ADDR_W'(1);
                            ptr_b_d = ptr_b_q + stride_q;
                            state_d = S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ptr_a_q    <= '0;
            ptr_b_q    <= '0;
            stride_q   <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_idx_q   <= '0;
            op_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_a_q    <= ptr_a_d;
            ptr_b_q    <= ptr_b_d;
            stride_q   <= stride_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_idx_q   <= op_idx_d;
            op_valid_q <= op_valid_d;
        end
    end

    assign rom_addr_a = ptr_a_q;
    assign rom_addr_b = ptr_b_q;
    assign op_a       = op_a_q;
    assign op_b       = op_b_q;
    assign op_idx     = op_idx_q;
    assign op_valid   = op_valid_q;
    assign op_last    = op_valid_q && (op_idx_q == last_idx);
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_rom_operand_sequencer.sv
// tb/tb_rom_operand_sequencer.sv - table-driven and scoreboard bench for rom_operand_sequencer
module tb_rom_operand_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, start, abort, op_ready;
    logic [2:0] base_a, base_b, stride_b;
    logic [3:0] len;
    logic [2:0] rom_addr_a, rom_addr_b;
    logic [7:0] rom_q_a, rom_q_b, op_a, op_b;
    logic [3:0] op_idx;
    logic       op_valid, op_last, busy, done;

    logic [7:0] rom [8];

    int checks = 0;
    int errors = 0;
    int hs_count = 0;
    int done_count = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] idx;
        logic       last;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [2:0] ba;
        logic [2:0] bb;
        logic [2:0] st;
        logic [3:0] ln;
        logic [7:0] first_a;
        logic [7:0] first_b;
        int         done_ticks;
    } vec_t;
    vec_t tbl[4];

    always #5 clk = ~clk;

    assign rom_q_a = rom[rom_addr_a];
    assign rom_q_b = rom[rom_addr_b];

    rom_operand_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .base_a(base_a), .base_b(base_b), .stride_b(stride_b), .len(len),
        .rom_addr_a(rom_addr_a), .rom_addr_b(rom_addr_b),
        .rom_q_a(rom_q_a), .rom_q_b(rom_q_b),
        .op_a(op_a), .op_b(op_b), .op_idx(op_idx), .op_valid(op_valid),
        .op_ready(op_ready), .op_last(op_last), .busy(busy), .done(done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a start for one edge and push the expected pair sequence
    task automatic do_start(input logic [2:0] ba, input logic [2:0] bb,
                            input logic [2:0] st, input logic [3:0] ln);
        logic [2:0] pa, pb;
        exp_t e;
        base_a = ba; base_b = bb; stride_b = st; len = ln; start = 1'b1;
        pa = ba; pb = bb;
        for (int k = 0; k < int'(ln); k++) begin
            e.a = 8'hA0 + {5'd0, pa};
            e.b = 8'hA0 + {5'd0, pb};
            e.idx = 4'(k);
            e.last = (k == int'(ln) - 1);
            sb.push_back(e);
            pa = pa + 3'd1;
            pb = pb + st;
        end
        tick();
        start = 1'b0;
        base_a = 3'd0; base_b = 3'd0; stride_b = 3'd0; len = 4'd0;
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        if (!done) begin
            errors++;
            $display("FAIL wait_done: timeout after %0d cycles", n);
        end
    endtask

    // Scoreboard consumer: every accepted pair must match the head of the queue
    always @(negedge clk) begin
        if (rst_n && op_valid && op_ready && !abort) begin
            hs_count++;
            if (sb.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL unexpected_pair: got idx %0d expected none", op_idx);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pair_a", {24'd0, op_a}, {24'd0, e.a});
                chk("pair_b", {24'd0, op_b}, {24'd0, e.b});
                chk("pair_idx", {28'd0, op_idx}, {28'd0, e.idx});
                chk("pair_last", {31'd0, op_last}, {31'd0, e.last});
            end
        end
        if (rst_n && done) done_count++;
    end

    initial begin
        int n, hs0, dc0;
        logic [7:0] ha, hb;
        logic [3:0] hi;

        for (int i = 0; i < 8; i++) rom[i] = 8'hA0 + 8'(i);
        tbl[0] = '{3'd6, 3'd1, 3'd3, 4'd4,  8'hA6, 8'hA1, 8};
        tbl[1] = '{3'd7, 3'd7, 3'd0, 4'd3,  8'hA7, 8'hA7, 6};
        tbl[2] = '{3'd0, 3'd5, 3'd7, 4'd15, 8'hA0, 8'hA5, 30};
        tbl[3] = '{3'd3, 3'd2, 3'd1, 4'd1,  8'hA3, 8'hA2, 2};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; op_ready = 1'b1;
        base_a = 3'd0; base_b = 3'd0; stride_b = 3'd0; len = 4'd0;
        tick(); tick();
        rst_n = 1'b1;
        chk("rst_valid", {31'd0, op_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ops", {8'd0, op_a, op_b, 4'd0, op_idx}, 32'd0);
        chk("rst_addr", {26'd0, rom_addr_a, rom_addr_b}, 32'd0);

        // Table-driven full runs with op_ready held high
        for (int t = 0; t < 4; t++) begin
            dc0 = done_count;
            do_start(tbl[t].ba, tbl[t].bb, tbl[t].st, tbl[t].ln);
            chk("t_busy_fetch", {31'd0, busy}, 32'd1);
            chk("t_valid_fetch", {31'd0, op_valid}, 32'd0);
            tick();
            chk("t_first_valid", {31'd0, op_valid}, 32'd1);
            chk("t_first_a", {24'd0, op_a}, {24'd0, tbl[t].first_a});
            chk("t_first_b", {24'd0, op_b}, {24'd0, tbl[t].first_b});
            wait_done(100, n);
            chk("t_done_latency", 32'(n + 1), 32'(tbl[t].done_ticks));
            tick();
            chk("t_busy_after", {31'd0, busy}, 32'd0);
            chk("t_done_pulse", {31'd0, done}, 32'd0);
            chk("t_sb_empty", 32'(sb.size()), 32'd0);
            chk("t_done_count", 32'(done_count - dc0), 32'd1);
        end

        // Backpressure: pair 0 must hold for 5 stalled cycles
        hs0 = hs_count; dc0 = done_count;
        op_ready = 1'b0;
        do_start(3'd2, 3'd4, 3'd1, 4'd2);
        tick();
        ha = op_a; hb = op_b; hi = op_idx;
        chk("bp_first_a", {24'd0, ha}, 32'hA2);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_hold", {op_valid, 7'd0, op_a, op_b, op_idx, 4'd0},
                {1'b1, 7'd0, ha, hb, hi, 4'd0});
        end
        op_ready = 1'b1;
        wait_done(50, n);
        tick();
        chk("bp_handshakes", 32'(hs_count - hs0), 32'd2);
        chk("bp_done_count", 32'(done_count - dc0), 32'd1);

        // Zero length
        hs0 = hs_count;
        do_start(3'd1, 3'd1, 3'd1, 4'd0);
        chk("z_done", {31'd0, done}, 32'd1);
        chk("z_busy", {31'd0, busy}, 32'd1);
        chk("z_valid", {31'd0, op_valid}, 32'd0);
        tick();
        chk("z_busy_after", {30'd0, busy, done}, 32'd0);
        chk("z_no_pairs", 32'(hs_count - hs0), 32'd0);

        // Abort one cycle after the 2nd handshake
        hs0 = hs_count; dc0 = done_count;
        do_start(3'd0, 3'd0, 3'd1, 4'd8);
        n = 0;
        while (hs_count - hs0 < 2 && n < 50) begin
            tick();
            n++;
        end
        chk("ab_reached", 32'(hs_count - hs0), 32'd2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_valid", {31'd0, op_valid}, 32'd0);
        chk("ab_busy", {31'd0, busy}, 32'd0);
        chk("ab_remaining", 32'(sb.size()), 32'd6);
        sb.delete();
        tick();
        chk("ab_no_done", 32'(done_count - dc0), 32'd0);
        do_start(3'd0, 3'd3, 3'd0, 4'd1);
        tick();
        chk("ab_next_a", {24'd0, op_a}, 32'hA0);
        chk("ab_next_idx", {28'd0, op_idx}, 32'd0);
        wait_done(20, n);
        tick();

        // start during PRESENT is ignored
        hs0 = hs_count;
        op_ready = 1'b0;
        do_start(3'd5, 3'd0, 3'd2, 4'd3);
        tick();
        base_a = 3'd1; len = 4'd7; start = 1'b1;
        tick();
        start = 1'b0; len = 4'd0; base_a = 3'd0;
        op_ready = 1'b1;
        wait_done(50, n);
        tick();
        chk("ign_handshakes", 32'(hs_count - hs0), 32'd3);
        chk("ign_sb_empty", 32'(sb.size()), 32'd0);

        // start and abort together in IDLE
        start = 1'b1; abort = 1'b1; len = 4'd3;
        tick();
        start = 1'b0; abort = 1'b0; len = 4'd0;
        chk("sa_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("sa_idle", {30'd0, busy, op_valid}, 32'd0);

        // Reset while a pair is presented
        op_ready = 1'b0;
        do_start(3'd4, 3'd4, 3'd4, 4'd5);
        tick();
        chk("rs_pre_valid", {31'd0, op_valid}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        sb.delete();
        chk("rs_outputs", {8'd0, op_a, op_b, op_idx, op_valid, busy, done, op_last}, 32'd0);
        chk("rs_addr", {26'd0, rom_addr_a, rom_addr_b}, 32'd0);
        op_ready = 1'b1;
        dc0 = done_count;
        do_start(3'd6, 3'd1, 3'd3, 4'd4);
        tick();
        chk("rs_rerun_a", {24'd0, op_a}, 32'hA6);
        wait_done(50, n);
        chk("rs_rerun_latency", 32'(n + 1), 32'd8);
        tick();
        chk("rs_rerun_sb", 32'(sb.size()), 32'd0);
        chk("rs_rerun_done", 32'(done_count - dc0), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
